// File: rtl/lfsr_checker.sv
// Self-synchronising receive-side checker for the XNOR LFSR stream.
// Locks after consecutive successor matches, then free-runs a local reference.
module lfsr_checker #(
  parameter int NUM_BITS   = 4,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [NUM_BITS-1:0] i_data,
  input  logic                i_clear_cnt,
  output logic                o_locked,
  output logic                o_err,
  output logic [CNT_W-1:0]    o_err_words,
  output logic [CNT_W-1:0]    o_err_bits
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  function automatic logic [15:0] tap_mask(input int n);
    case (n)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0006;
    endcase
  endfunction

  localparam logic [NUM_BITS-1:0] TAPS =
    NUM_BITS'(tap_mask(NUM_BITS));
  localparam logic [NUM_BITS-1:0] ONES = '1;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
  localparam logic [UW-1:0] UNLK_V = UW'(UNLOCK_CNT);
  localparam int SW = ((CNT_W > 5) ? CNT_W : 5) + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [SW-1:0] CMAX_W = SW'(CMAX);

  function automatic logic [NUM_BITS-1:0] nxt(
    input logic [NUM_BITS-1:0] w
  );
    return {w[NUM_BITS-2:0], ~^(w & TAPS)};
  endfunction

  function automatic logic [4:0] popcnt(
    input logic [NUM_BITS-1:0] v
  );
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < NUM_BITS; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  state_t              state_q, state_d;
  logic                have_q, have_d;
  logic [MW-1:0]       match_q, match_d;
  logic [UW-1:0]       miss_q, miss_d;
  logic [NUM_BITS-1:0] prev_q, prev_d;
  logic [NUM_BITS-1:0] ref_q, ref_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [CNT_W-1:0]    bits_q, bits_d;

  logic [NUM_BITS-1:0] exp_w;
  logic [NUM_BITS-1:0] diff;
  logic [SW-1:0]       bsum;

  always_comb begin
    state_d = state_q;
    have_d  = have_q;
    match_d = match_q;
    miss_d  = miss_q;
    prev_d  = prev_q;
    ref_d   = ref_q;
    err_d   = 1'b0;
    words_d = words_q;
    bits_d  = bits_q;
    exp_w   = nxt(ref_q);
    diff    = i_data ^ exp_w;
    bsum    = SW'(bits_q) + SW'(popcnt(diff));
    if (i_valid) begin
      case (state_q)
        SEARCH: begin
          prev_d = i_data;
          have_d = 1'b1;
          if (have_q) begin
            if (i_data == nxt(prev_q) && i_data != ONES) begin
              match_d = match_q + MW'(1);
              if (match_d == LOCK_V) begin
                state_d = LOCKED;
                ref_d   = i_data;
                miss_d  = '0;
                match_d = '0;
              end
            end else begin
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          ref_d = exp_w;
          if (diff != '0) begin
            err_d   = 1'b1;
            words_d = (words_q == CMAX) ? CMAX
                    : words_q + CNT_W'(1);
            bits_d  = (bsum > CMAX_W) ? CMAX
                    : bsum[CNT_W-1:0];
            miss_d  = miss_q + UW'(1);
            // Persistent misses mean the link slipped; hunt again.
            if (miss_d == UNLK_V) begin
              state_d = SEARCH;
              prev_d  = i_data;
              have_d  = 1'b1;
              match_d = '0;
              miss_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (i_clear_cnt) begin
      words_d = '0;
      bits_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= SEARCH;
      have_q  <= 1'b0;
      match_q <= '0;
      miss_q  <= '0;
      prev_q  <= '0;
      ref_q   <= '0;
      err_q   <= 1'b0;
      words_q <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      have_q  <= have_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      prev_q  <= prev_d;
      ref_q   <= ref_d;
      err_q   <= err_d;
      words_q <= words_d;
      bits_q  <= bits_d;
    end
  end

  assign o_locked    = (state_q == LOCKED);
  assign o_err       = err_q;
  assign o_err_words = words_q;
  assign o_err_bits  = bits_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised and directed bench for lfsr_checker (N=4, 4-bit counters)
// against a behavioural stream model.
module tb_lfsr_checker;

  localparam int N    = 4;
  localparam int LK   = 4;
  localparam int UL   = 3;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam int ONES = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  data = '0;
  logic          locked;
  logic          err;
  logic [CW-1:0] words;
  logic [CW-1:0] bits;

  int vectors = 0;
  int miscompares = 0;

  int m_lock, m_have, m_prev, m_match, m_ref, m_miss;
  int m_err, m_words, m_bits;
  int tx;

  lfsr_checker #(
    .NUM_BITS(N), .LOCK_CNT(LK),
    .UNLOCK_CNT(UL), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid),
    .i_data(data), .i_clear_cnt(clr),
    .o_locked(locked), .o_err(err),
    .o_err_words(words), .o_err_bits(bits)
  );

  always #5 clk = ~clk;

  // Taps {4,3}: feedback is XNOR of bits 3 and 2.
  function automatic int nx(int w);
    int fb;
    fb = 1 ^ (((w >> 3) ^ (w >> 2)) & 1);
    return ((w << 1) & ONES) | fb;
  endfunction

  task automatic check(string tag, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_have = 0; m_prev = 0; m_match = 0;
    m_ref = 0; m_miss = 0; m_err = 0;
    m_words = 0; m_bits = 0;
  endtask

  task automatic model_step(bit v, int d, bit c);
    int e;
    m_err = 0;
    if (v && m_lock == 0) begin
      if (m_have != 0) begin
        if (d == nx(m_prev) && d != ONES) m_match++;
        else m_match = 0;
      end
      m_prev = d;
      m_have = 1;
      if (m_match == LK) begin
        m_lock = 1; m_ref = d; m_miss = 0; m_match = 0;
      end
    end else if (v) begin
      e = nx(m_ref);
      m_ref = e;
      if (d != e) begin
        m_err = 1;
        m_words = (m_words + 1 > MAXC) ? MAXC : m_words + 1;
        m_bits = m_bits + $countones(d ^ e);
        if (m_bits > MAXC) m_bits = MAXC;
        m_miss++;
        if (m_miss == UL) begin
          m_lock = 0; m_prev = d; m_have = 1; m_match = 0;
        end
      end else begin
        m_miss = 0;
      end
    end
    if (c) begin
      m_words = 0;
      m_bits = 0;
    end
  endtask

  task automatic compare_all();
    check("locked", int'(locked), m_lock);
    check("err", int'(err), m_err);
    check("err_words", int'(words), m_words);
    check("err_bits", int'(bits), m_bits);
  endtask

  task automatic cyc(bit v, int d, bit c);
    valid = v;
    data = v ? N'(d) : N'($urandom);
    clr = c;
    @(posedge clk);
    model_step(v, d & ONES, c);
    #1;
    compare_all();
    valid = 1'b0;
    clr = 1'b0;
  endtask

  task automatic send(int mask);
    cyc(1'b1, tx ^ mask, 1'b0);
    tx = nx(tx);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
  endtask

  task automatic reset_cyc();
    rst_n = 1'b0;
    valid = 1'b1;
    data = N'($urandom);
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
    check("rst_locked", int'(locked), 0);
    check("rst_words", int'(words), 0);
    rst_n = 1'b1;
    valid = 1'b0;
  endtask

  initial begin
    int r, mask;
    bit c;
    model_reset();
    reset_cyc();

    tx = 0;
    for (int i = 0; i < 16; i++) begin
      send(0);
      if (i == 3) check("pre_lock", int'(locked), 0);
      if (i == 4) check("lock_at_E", int'(locked), 1);
    end

    while (tx != 13) send(0);
    cyc(1'b1, 15, 1'b0);
    tx = nx(tx);
    check("single_err", int'(err), 1);
    check("single_words", int'(words), 1);
    check("single_bits", int'(bits), 1);
    send(0);
    send(0);
    check("ref_intact", int'(err), 0);

    for (int i = 0; i < 4; i++) begin
      send(0);
      idle(5);
    end
    check("gap_locked", int'(locked), 1);

    cyc(1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) send(1);
    check("unlock_fall", int'(locked), 0);
    check("unlock_words", int'(words), 3);
    for (int i = 0; i < 5; i++) begin
      send(0);
      if (i == 3) check("relock_pre", int'(locked), 0);
    end
    check("relock", int'(locked), 1);

    reset_cyc();
    for (int i = 0; i < 20; i++) cyc(1'b1, ONES, 1'b0);
    check("ones_nolock", int'(locked), 0);
    tx = 0;
    for (int i = 0; i < 5; i++) send(0);
    check("ones_relock", int'(locked), 1);

    for (int i = 0; i < 20; i++) begin
      send(1 << (i % 4));
      send(0);
    end
    check("sat_words", int'(words), MAXC);
    check("sat_bits", int'(bits), MAXC);

    cyc(1'b1, tx ^ 2, 1'b1);
    tx = nx(tx);
    check("clr_wins", int'(words), 0);
    check("clr_err", int'(err), 1);

    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 249) == 0) begin
        reset_cyc();
      end else if (r < 12) begin
        cyc(1'b0, 0, c);
      end else begin
        mask = (r < 24) ? $urandom_range(1, ONES) : 0;
        cyc(1'b1, tx ^ mask, c);
        tx = nx(tx);
      end
    end

    for (int i = 0; i < 6; i++) send(0);
    check("final_locked", int'(locked), 1);
    reset_cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
